mlp_seq_ctrl: RTL

MLP_SEQ_CTRL -- requirements
Module: mlp_seq_ctrl

---
 rtl/mlp_seq_ctrl_if.sv | 43 ++++
 rtl/mlp_seq_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mlp_seq_ctrl_if.sv
// Control/strobe bundle between the MLP sequencer and its MAC datapath.
// Widths are derived from the layer sizes exactly as the sequencer derives them.
interface mlp_seq_ctrl_if #(
    parameter int N_INPUTS = 2,
    parameter int N_HIDDEN = 4,
    parameter int N_OUTPUT = 1
);
    localparam int SRC_MAX = (N_INPUTS > N_HIDDEN) ? N_INPUTS : N_HIDDEN;
    localparam int DST_MAX = (N_HIDDEN > N_OUTPUT) ? N_HIDDEN : N_OUTPUT;
    localparam int W0      = N_HIDDEN * (N_INPUTS + 1);
    localparam int W1      = N_OUTPUT * (N_HIDDEN + 1);
    localparam int WGT_MAX = (W0 > W1) ? W0 : W1;
    localparam int SRC_W   = (SRC_MAX > 1) ? $clog2(SRC_MAX) : 1;
    localparam int DST_W   = (DST_MAX > 1) ? $clog2(DST_MAX) : 1;
    localparam int WADDR_W = (WGT_MAX > 1) ? $clog2(WGT_MAX) : 1;

    logic               start;
    logic               done_clr;
    logic               irq_en;
    logic               busy;
    logic               done;
    logic               irq;
    logic               layer;
    logic [WADDR_W-1:0] wgt_addr;
    logic [SRC_W-1:0]   src_addr;
    logic [DST_W-1:0]   dst_addr;
    logic               acc_load;
    logic               mac_en;
    logic               act_wr;
    logic               relu_en;

    modport master (
        input  start, done_clr, irq_en,
        output busy, done, irq, layer, wgt_addr, src_addr, dst_addr,
               acc_load, mac_en, act_wr, relu_en
    );

    modport slave (
        output start, done_clr, irq_en,
        input  busy, done, irq, layer, wgt_addr, src_addr, dst_addr,
               acc_load, mac_en, act_wr, relu_en
    );
endinterface

// File: rtl/mlp_seq_ctrl.sv
// Sequencer for a two-layer MLP forward pass: BIAS, K x MAC, ACT per neuron, all outputs registered.
// Pass takes N_HIDDEN*(N_INPUTS+2)+N_OUTPUT*(N_HIDDEN+2) cycles; no backpressure, the datapath must keep pace.
module mlp_seq_ctrl #(
    parameter int N_INPUTS = 2,
    parameter int N_HIDDEN = 4,
    parameter int N_OUTPUT = 1
) (
    input  logic           clk,
    input  logic           rst,
    mlp_seq_ctrl_if.master bus
);
    localparam int SRC_MAX = (N_INPUTS > N_HIDDEN) ? N_INPUTS : N_HIDDEN;
    localparam int DST_MAX = (N_HIDDEN > N_OUTPUT) ? N_HIDDEN : N_OUTPUT;
    localparam int W0      = N_HIDDEN * (N_INPUTS + 1);
    localparam int W1      = N_OUTPUT * (N_HIDDEN + 1);
    localparam int WGT_MAX = (W0 > W1) ? W0 : W1;
    localparam int SRC_W   = (SRC_MAX > 1) ? $clog2(SRC_MAX) : 1;
    localparam int DST_W   = (DST_MAX > 1) ? $clog2(DST_MAX) : 1;
    localparam int WADDR_W = (WGT_MAX > 1) ? $clog2(WGT_MAX) : 1;

    localparam logic [SRC_W-1:0]   K0_LAST = SRC_W'(N_INPUTS - 1);
    localparam logic [SRC_W-1:0]   K1_LAST = SRC_W'(N_HIDDEN - 1);
    localparam logic [DST_W-1:0]   M0_LAST = DST_W'(N_HIDDEN - 1);
    localparam logic [DST_W-1:0]   M1_LAST = DST_W'(N_OUTPUT - 1);
    localparam logic [WADDR_W-1:0] W0_LAST = WADDR_W'(W0 - 1);
    localparam logic [WADDR_W-1:0] W1_LAST = WADDR_W'(W1 - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BIAS = 3'd1,
        MAC  = 3'd2,
        ACT  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             state_q, state_nxt;
    logic               layer_q, layer_nxt;
    logic [DST_W-1:0]   n_q, n_nxt;
    logic [SRC_W-1:0]   k_q, k_nxt;
    logic [WADDR_W-1:0] wgt_q, wgt_nxt;

    logic [SRC_W-1:0]   k_last;
    logic [DST_W-1:0]   n_last;

    logic               busy_q, done_q, irq_q;
    logic               acc_load_q, mac_en_q, act_wr_q, relu_en_q;
    logic [SRC_W-1:0]   src_q;
    logic [DST_W-1:0]   dst_q;

    logic               busy_nxt;
    logic [SRC_W-1:0]   src_nxt;
    logic [DST_W-1:0]   dst_nxt;

    assign k_last = layer_q ? K1_LAST : K0_LAST;
    assign n_last = layer_q ? M1_LAST : M0_LAST;

    // Weights of a layer are laid out bias-first per neuron, so the read
    // index simply advances by one on every BIAS/MAC cycle and holds in ACT.
    always_comb begin
        state_nxt = state_q;
        layer_nxt = layer_q;
        n_nxt     = n_q;
        k_nxt     = k_q;
        wgt_nxt   = wgt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = BIAS;
                    layer_nxt = 1'b0;
                    n_nxt     = '0;
                    k_nxt     = '0;
                    wgt_nxt   = '0;
                end
            end
            BIAS: begin
                state_nxt = MAC;
                k_nxt     = '0;
                wgt_nxt   = wgt_q + WADDR_W'(1);
            end
            MAC: begin
                if (k_q == k_last) begin
                    state_nxt = ACT;
                end else begin
                    k_nxt   = k_q + SRC_W'(1);
                    wgt_nxt = wgt_q + WADDR_W'(1);
                end
            end
            ACT: begin
                k_nxt = '0;
                if (n_q != n_last) begin
                    state_nxt = BIAS;
                    n_nxt     = n_q + DST_W'(1);
                    wgt_nxt   = wgt_q + WADDR_W'(1);
                end else if (!layer_q) begin
                    state_nxt = BIAS;
                    layer_nxt = 1'b1;
                    n_nxt     = '0;
                    wgt_nxt   = '0;
                end else begin
                    state_nxt = DONE;
                    n_nxt     = '0;
                    wgt_nxt   = '0;
                end
            end
            DONE: begin
                // start outranks done_clr so a back-to-back pass is never lost
                if (bus.start) begin
                    state_nxt = BIAS;
                    layer_nxt = 1'b0;
                    n_nxt     = '0;
                    k_nxt     = '0;
                    wgt_nxt   = '0;
                end else if (bus.done_clr) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        busy_nxt = (state_nxt == BIAS) || (state_nxt == MAC) || (state_nxt == ACT);
        src_nxt  = (state_nxt == MAC) ? k_nxt : '0;
        dst_nxt  = busy_nxt ? n_nxt : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            layer_q    <= 1'b0;
            n_q        <= '0;
            k_q        <= '0;
            wgt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            irq_q      <= 1'b0;
            acc_load_q <= 1'b0;
            mac_en_q   <= 1'b0;
            act_wr_q   <= 1'b0;
            relu_en_q  <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
        end else begin
            state_q    <= state_nxt;
            layer_q    <= layer_nxt;
            n_q        <= n_nxt;
            k_q        <= k_nxt;
            wgt_q      <= wgt_nxt;
            busy_q     <= busy_nxt;
            done_q     <= (state_nxt == DONE);
            irq_q      <= done_q & bus.irq_en;
            acc_load_q <= (state_nxt == BIAS);
            mac_en_q   <= (state_nxt == MAC);
            act_wr_q   <= (state_nxt == ACT);
            relu_en_q  <= (state_nxt == ACT) && !layer_nxt;
            src_q      <= src_nxt;
            dst_q      <= dst_nxt;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.irq      = irq_q;
    assign bus.layer    = layer_q;
    assign bus.wgt_addr = wgt_q;
    assign bus.src_addr = src_q;
    assign bus.dst_addr = dst_q;
    assign bus.acc_load = acc_load_q;
    assign bus.mac_en   = mac_en_q;
    assign bus.act_wr   = act_wr_q;
    assign bus.relu_en  = relu_en_q;

    a_one_strobe: assert property (@(posedge clk) disable iff (rst)
        $onehot0({acc_load_q, mac_en_q, act_wr_q}));
    a_k_bound: assert property (@(posedge clk) disable iff (rst) k_q <= k_last);
    a_n_bound: assert property (@(posedge clk) disable iff (rst) n_q <= n_last);
    a_w_bound: assert property (@(posedge clk) disable iff (rst)
        wgt_q <= (layer_q ? W1_LAST : W0_LAST));
endmodule
